// File: rtl/vm_order_initiator.sv
// Customer-side order front end for the vending core: collects coins into a credit,
// issues one order per selection and turns the core's answer into panel event pulses.
module vm_order_initiator #(
    parameter int MAX_CREDIT  = 127,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_in,
    input  logic [1:0] coin_denom,
    input  logic       sel_valid,
    input  logic [3:0] sel_id,
    input  logic       cancel,
    output logic       order_coin,
    output logic [6:0] order_value,
    output logic [3:0] order_id,
    input  logic       vm_product,
    input  logic       vm_error,
    input  logic [6:0] vm_change,
    input  logic       vm_done,
    output logic [6:0] credit,
    output logic       busy,
    output logic       coin_reject,
    output logic       sel_reject,
    output logic       vend_ok,
    output logic       vend_fail,
    output logic       timeout_err,
    output logic       refund_valid,
    output logic [6:0] refund_amt
);

    // state      | meaning
    // COLLECT    | accumulating coins, waiting for a selection or cancel
    // ISSUE      | order strobe to the core is high this cycle
    // WAIT_RES   | waiting for product/error from the core
    // WAIT_DONE  | result captured, waiting for done
    // FINISH     | result pulses and change refund are out this cycle
    typedef enum logic [2:0] {
        S_COLLECT,
        S_ISSUE,
        S_WAIT_RES,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]    MAX_C8   = 8'(MAX_CREDIT);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;

    logic [6:0]    credit_q, credit_d;
    logic [6:0]    order_value_q, order_value_d;
    logic [3:0]    order_id_q, order_id_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ok_q, ok_d;
    logic [6:0]    chg_q, chg_d;
    logic          order_coin_q, order_coin_d;
    logic          busy_q, busy_d;
    logic          coin_reject_q, coin_reject_d;
    logic          sel_reject_q, sel_reject_d;
    logic          vend_ok_q, vend_ok_d;
    logic          vend_fail_q, vend_fail_d;
    logic          timeout_err_q, timeout_err_d;
    logic          refund_valid_q, refund_valid_d;
    logic [6:0]    refund_amt_q, refund_amt_d;

    logic [6:0] denom_val;
    logic [7:0] coin_sum;
    logic       coin_fits;
    logic       sel_ok;
    logic       in_wait;
    logic       timer_tc;
    logic       res_seen;

    always_comb begin
        denom_val = 7'd5;
        case (coin_denom)
            2'd0: denom_val = 7'd5;
            2'd1: denom_val = 7'd10;
            2'd2: denom_val = 7'd20;
            2'd3: denom_val = 7'd50;
            default: denom_val = 7'd5;
        endcase
    end

    // Sum at 8 bits so a coin near the ceiling can never wrap into a small credit
    assign coin_sum  = {1'b0, credit_q} + {1'b0, denom_val};
    assign coin_fits = (coin_sum <= MAX_C8);
    assign sel_ok    = sel_valid && (sel_id >= 4'd1) && (sel_id <= 4'd10) && (credit_q != 7'd0);
    assign in_wait   = (state_q == S_WAIT_RES) || (state_q == S_WAIT_DONE);
    assign timer_tc  = in_wait && (timer_q == '0);
    assign res_seen  = vm_product || vm_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_COLLECT;
            credit_q       <= '0;
            order_value_q  <= '0;
            order_id_q     <= '0;
            timer_q        <= '0;
            ok_q           <= 1'b0;
            chg_q          <= '0;
            order_coin_q   <= 1'b0;
            busy_q         <= 1'b0;
            coin_reject_q  <= 1'b0;
            sel_reject_q   <= 1'b0;
            vend_ok_q      <= 1'b0;
            vend_fail_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_amt_q   <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            order_value_q  <= order_value_d;
            order_id_q     <= order_id_d;
            timer_q        <= timer_d;
            ok_q           <= ok_d;
            chg_q          <= chg_d;
            order_coin_q   <= order_coin_d;
            busy_q         <= busy_d;
            coin_reject_q  <= coin_reject_d;
            sel_reject_q   <= sel_reject_d;
            vend_ok_q      <= vend_ok_d;
            vend_fail_q    <= vend_fail_d;
            timeout_err_q  <= timeout_err_d;
            refund_valid_q <= refund_valid_d;
            refund_amt_q   <= refund_amt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT:   if (!cancel && sel_ok) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_RES;
            S_WAIT_RES:  if (timer_tc) state_d = S_COLLECT;
                         else if (res_seen) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (timer_tc) state_d = S_COLLECT;
                         else if (vm_done) state_d = S_FINISH;
            S_FINISH:    state_d = S_COLLECT;
            default:     state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        credit_d       = credit_q;
        order_value_d  = order_value_q;
        order_id_d     = order_id_q;
        timer_d        = timer_q;
        ok_d           = ok_q;
        chg_d          = chg_q;
        coin_reject_d  = 1'b0;
        sel_reject_d   = 1'b0;
        vend_ok_d      = 1'b0;
        vend_fail_d    = 1'b0;
        timeout_err_d  = 1'b0;
        refund_valid_d = 1'b0;
        refund_amt_d   = '0;
        order_coin_d   = (state_d == S_ISSUE);
        busy_d         = (state_d != S_COLLECT);

        if (state_q == S_COLLECT) begin
            if (cancel) begin
                if (credit_q != 7'd0) begin
                    refund_valid_d = 1'b1;
                    refund_amt_d   = credit_q;
                    credit_d       = '0;
                end
                sel_reject_d  = sel_valid;
                coin_reject_d = coin_in;
            end else if (sel_valid) begin
                if (sel_ok) begin
                    order_id_d    = sel_id;
                    order_value_d = credit_q;
                end else begin
                    sel_reject_d = 1'b1;
                end
                coin_reject_d = coin_in;
            end else if (coin_in) begin
                if (coin_fits) credit_d = coin_sum[6:0];
                else           coin_reject_d = 1'b1;
            end
        end else begin
            coin_reject_d = coin_in;
            sel_reject_d  = sel_valid;
        end

        case (state_q)
            S_ISSUE: timer_d = TMR_LOAD;
            S_WAIT_RES, S_WAIT_DONE: begin
                if (timer_tc) begin
                    timeout_err_d  = 1'b1;
                    refund_valid_d = 1'b1;
                    refund_amt_d   = order_value_q;
                    credit_d       = '0;
                    order_value_d  = '0;
                    order_id_d     = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (state_q == S_WAIT_RES && res_seen) begin
                        ok_d  = vm_product;
                        chg_d = vm_change;
                    end
                    if (state_q == S_WAIT_DONE && vm_done) begin
                        vend_ok_d   = ok_q;
                        vend_fail_d = !ok_q;
                        credit_d    = '0;
                        if (chg_q != 7'd0) begin
                            refund_valid_d = 1'b1;
                            refund_amt_d   = chg_q;
                        end
                    end
                end
            end
            S_FINISH: begin
                order_value_d = '0;
                order_id_d    = '0;
            end
            default: ;
        endcase
    end

    assign order_coin   = order_coin_q;
    assign order_value  = order_value_q;
    assign order_id     = order_id_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
    assign coin_reject  = coin_reject_q;
    assign sel_reject   = sel_reject_q;
    assign vend_ok      = vend_ok_q;
    assign vend_fail    = vend_fail_q;
    assign timeout_err  = timeout_err_q;
    assign refund_valid = refund_valid_q;
    assign refund_amt   = refund_amt_q;

endmodule

// File: doc/vm_order_initiator.md
# vm_order_initiator

Customer-side front end that drives the vending core's order interface (`coin`, `value_coin`, `id_item` in; `product`, `error_o`, `coin_change`, `done` out). It accumulates individual coin insertions into a credit, accepts an item selection, and issues a single order to the core. It then captures the core's result and reports dispense, fail, refund and timeout events to the panel logic.

## Interface
Parameters:
- `MAX_CREDIT`, 127: credit ceiling; must be ≤ 127 to fit 7 bits.
- `TIMEOUT_CYC`, 1000: cycles allowed in WAIT_RES plus WAIT_DONE before abort; must be ≥ 4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `coin_in`  in  1  one-cycle pulse: a coin was inserted.
- `coin_denom`  in  2  coin value: 0→5, 1→10, 2→20, 3→50.
- `sel_valid`  in  1  one-cycle pulse: an item was selected.
- `sel_id`  in  4  selected item ID.
- `cancel`  in  1  one-cycle pulse: the customer pressed cancel.
- `order_coin`  out  1  one-cycle order strobe to the core's `coin`.
- `order_value`  out  7  credit offered, to the core's `value_coin`.
- `order_id`  out  4  item ID, to the core's `id_item`.
- `vm_product`, `vm_error`  in  1 each  from the core's `product` / `error_o`.
- `vm_change`  in  7  from the core's `coin_change`.
- `vm_done`  in  1  from the core's `done`.
- `credit`  out  7  current accumulated credit.
- `busy`  out  1  high whenever state ≠ COLLECT.
- `coin_reject`  out  1  pulse: the coin was not accepted (return it mechanically).
- `sel_reject`  out  1  pulse: the selection was ignored.
- `vend_ok`, `vend_fail`, `timeout_err`  out  1 each  result pulses.
- `refund_valid`  out  1  pulse qualifying `refund_amt`.
- `refund_amt`  out  7  amount to pay out.

## Operation
- All outputs are registered.
- Reset (`rst_n`=0) asynchronously forces:
  - state COLLECT;
  - `credit`, `order_value`, `order_id` and the timer to 0;
  - every output to 0.
- Reset mid-order abandons the order with no refund pulse.
- States: COLLECT, ISSUE, WAIT_RES, WAIT_DONE, FINISH.
- COLLECT, input priority `cancel` > `sel_valid` > `coin_in`:
  - `cancel` with `credit`>0: pulse `refund_valid` with `refund_amt`=`credit`; `credit`←0. With `credit`=0 it has no effect.
  - `sel_valid` accepted when `sel_id` is in 1..10 and `credit`>0: latch `order_id`←`sel_id`, `order_value`←`credit`, go to ISSUE.
  - `sel_valid` otherwise: pulse `sel_reject`, stay in COLLECT.
  - `coin_in`: if `credit`+denom ≤ `MAX_CREDIT`, `credit` increases by the denom; otherwise pulse `coin_reject` and leave `credit` unchanged. The sum is computed at 8 bits, so there is no wrap.
  - A `coin_in` that loses to `cancel` or `sel_valid` in the same cycle pulses `coin_reject`.
- In any state other than COLLECT:
  - `coin_in` pulses `coin_reject`;
  - `sel_valid` pulses `sel_reject`;
  - `cancel` is ignored.
- ISSUE: `order_coin`=1 for exactly one cycle; clear the timer; go to WAIT_RES.
- WAIT_RES: on `vm_product` or `vm_error`, capture `ok`←`vm_product` and `chg`←`vm_change`, then go to WAIT_DONE.
- WAIT_DONE: on `vm_done`, go to FINISH.
- FINISH (one cycle):
  - pulse `vend_ok` if `ok`, else pulse `vend_fail`;
  - if `chg`≠0, pulse `refund_valid` with `refund_amt`=`chg`;
  - `credit`←0; return to COLLECT.
- Timeout:
  - The timer counts every cycle in WAIT_RES and WAIT_DONE.
  - When it reaches `TIMEOUT_CYC`: pulse `timeout_err`, pulse `refund_valid` with `refund_amt`=`order_value`, set `credit`←0, return to COLLECT.
  - A timeout takes precedence over a `vm_done` arriving in the same cycle.
- `order_value` and `order_id` stay stable from ISSUE until FINISH or timeout exits, then return to 0.

## Timing
- Cycle numbering from a `sel_valid` sampled at edge 0:
  - cycle 1: ISSUE, `order_coin`=1;
  - cycle 2: core result visible, captured at edge 3;
  - cycle 3: `vm_done`=1;
  - cycle 4: FINISH, result pulses.
- Selection-to-result latency is therefore 4 cycles against the core.
- A coin updates `credit` the cycle after `coin_in` is sampled.
- All pulses are exactly one cycle wide.
- At most one `refund_valid` per transaction.
- The block accepts new coins the cycle after FINISH.

## Test plan
- Reset, then coins 10 and 5, select id 3 (price 15) → `order_coin` at cycle 1 with `order_value`=15, `order_id`=3; `vend_ok` at cycle 4; no refund; `credit`=0.
- Coins 50 and 20, select id 2 (price 10) → `vend_ok`, `refund_valid` with `refund_amt`=60.
- Coin 5, select id 4 (price 20) → core error; `vend_fail`, `refund_amt`=5.
- Credit 120, insert coin 20 → `coin_reject`, `credit` stays 120. Then `cancel` → `refund_amt`=120. Then `sel_valid` with id 11 and with `credit`=0 → `sel_reject` both times.
- Order issued with the core stubbed to never respond, `TIMEOUT_CYC`=8 → `timeout_err` 8 cycles after ISSUE, `refund_amt`=`order_value`. Then assert `rst_n` low in WAIT_DONE → all outputs 0 immediately.
- Same-cycle `cancel`+`sel_valid`+`coin_in` with `credit`=10 → refund of 10, `coin_reject`, no order issued.
